fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Sequencer and arbiter in front of one FIFObuffer instance. Shares its single write port
//  round-robin between NREQ producers, with bounded burst locking. Forwards consumer reads
//  and tracks occupancy locally, so the FIFO's own counters are never trusted. Guarantees
//  RD and WR are never issued to the FIFO in the same cycle.
// PARAMETERS
//  NREQ      4   number of producer ports (2..8)
//  DW        32  data width; must match the FIFO data width
//  DEPTH     8   FIFO entries; occupancy ceiling
//  MAX_BURST 4   max consecutive writes granted to one owner before rotation (>=1)
// PORTS
//  Clk          in   1          single clock; all state updates on posedge
//  Rst          in   1          reset: synchronous, active-high
//  req          in   NREQ       per-producer write request; hold with data until ack
//  wdata        in   NREQ*DW    producer data; slice i = wdata[i*DW +: DW]
//  ack          out  NREQ       one-hot write accept; the word is written at this edge
//  rd_req       in   1          consumer read request
//  rd_valid     out  1          rd_data valid; registered, 1 cycle after fifo_RD
//  rd_data      out  DW         passthrough of fifo_dataOut
//  fifo_EN      out  1          constant 1
//  fifo_Rst     out  1          equals Rst
//  fifo_WR      out  1          FIFO write strobe (= |ack)
//  fifo_RD      out  1          FIFO read strobe
//  fifo_dataIn  out  DW         data of the granted producer; 0 when no grant
//  fifo_dataOut in   DW         FIFO registered read data
//  level        out  clog2(DEPTH+1)  current occupancy
//  full/empty   out  1          level==DEPTH / level==0
//  grant_id     out  clog2(NREQ)     current or most recent owner index
// BEHAVIOUR
//  - Reset values (Rst high at an edge): level=0, ptr=0, state=IDLE, burst_cnt=0,
//    rd_valid=0, grant_id=0. While Rst is high, ack=0, fifo_WR=0, fifo_RD=0 combinationally.
//  - Read path, priority over writes:
//    - fifo_RD = rd_req & !empty & !Rst.
//    - rd_valid <= fifo_RD, so data is on rd_data exactly one cycle after fifo_RD.
//    - rd_req while empty is ignored; it is not queued.
//  - Write permission: wr_ok = !full & !fifo_RD & !Rst. If wr_ok=0, ack=0 and the arbiter
//    state holds.
//  - Grant is combinational from the registered state.
//  - IDLE state:
//    - Grant the first req[i] scanning from ptr upward, mod NREQ.
//    - On an accepted write: owner<=i, burst_cnt<=1, go to OWN (if MAX_BURST==1,
//      rotate instead).
//  - OWN state:
//    - If req[owner] is high, grant the owner.
//    - On accept: burst_cnt++. When burst_cnt reaches MAX_BURST: ptr<=owner+1, go to IDLE.
//    - If req[owner] is low: ptr<=owner+1, re-arbitrate in the same cycle as IDLE
//      (no bubble).
//  - Rotation with a single active requester re-grants it the next cycle (no idle cycle).
//  - level update: +1 on fifo_WR, -1 on fifo_RD, never both. level never exceeds DEPTH and
//    never goes below 0.
//  - ptr and owner wrap NREQ-1 -> 0.
//  - Reset mid-burst drops ownership; a producer that was not acked must re-present its word.
// TESTING
//  1. Rst high 2 cycles -> level=0, empty=1, ack=0, fifo_Rst=1, fifo_EN=1; after release
//     fifo_Rst=0.
//  2. DEPTH=8, MAX_BURST=4, req[0] high 10 cycles with data 0..9 -> 8 acks (data 0..7),
//     full=1 at cycle 8, ack=0 afterwards.
//  3. NREQ=4, MAX_BURST=2, all req high, FIFO draining -> grant_id sequence 0,0,1,1,2,2,3,3,0.
//  4. level=3, rd_req and req[1] in the same cycle -> fifo_RD=1, fifo_WR=0, ack[1]=0, level=2;
//     next cycle rd_valid=1 with the oldest word, and ack[1]=1.
//  5. level=0, rd_req=1 -> fifo_RD=0, rd_valid stays 0. Then req[2] with 0xA5 -> ack[2],
//     level=1.
//  6. Rst pulsed during OWN with burst_cnt=2 -> next cycle state=IDLE, ptr=0, level=0,
//     no ack during Rst.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/consumer side of the FIFO write arbiter: per-producer write handshake plus the
// consumer read request and registered read-valid.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    ack;
  logic               rd_req;
  logic               rd_valid;
  logic [DW-1:0]      rd_data;

  modport master (
    output req, wdata, rd_req,
    input  ack, rd_valid, rd_data
  );

  modport slave (
    input  req, wdata, rd_req,
    output ack, rd_valid, rd_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with burst locking in front of a single FIFO. Reads take priority
// over writes and occupancy is tracked locally.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                       Clk,
  input  logic                       Rst,
  fifo_wr_arbiter_if.slave           bus,
  output logic                       fifo_EN,
  output logic                       fifo_Rst,
  output logic                       fifo_WR,
  output logic                       fifo_RD,
  output logic [DW-1:0]              fifo_dataIn,
  input  logic [DW-1:0]              fifo_dataOut,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(NREQ)-1:0]    grant_id
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic {StIdle, StOwn} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [LW-1:0]   level_q, level_d;
  logic            rd_valid_q;

  logic            own_hold, owner_drop, gnt_valid, accept, wr_ok, rd_fire;
  logic [IW-1:0]   scan_base, gnt_idx, cand;
  logic [NREQ-1:0] ack;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (32'(v) == NREQ - 1) ? '0 : v + 1'b1;
  endfunction

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign rd_fire = bus.rd_req & ~empty & ~Rst;
  assign wr_ok   = ~full & ~rd_fire & ~Rst;

  // Grant is purely a function of registered state and the current requests.
  always_comb begin
    own_hold   = 1'b0;
    owner_drop = 1'b0;
    scan_base  = ptr_q;
    gnt_valid  = 1'b0;
    gnt_idx    = '0;
    cand       = '0;
    if (state_q == StOwn) begin
      if (bus.req[owner_q]) begin
        own_hold = 1'b1;
      end else begin
        // Owner let go: rotate past it and re-arbitrate this same cycle.
        owner_drop = 1'b1;
        scan_base  = wrap_inc(owner_q);
      end
    end
    if (own_hold) begin
      gnt_valid = 1'b1;
      gnt_idx   = owner_q;
    end else begin
      cand = scan_base;
      for (int k = 0; k < int'(NREQ); k++) begin
        if (!gnt_valid && bus.req[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
        cand = wrap_inc(cand);
      end
    end
  end

  assign accept = gnt_valid & wr_ok;

  always_comb begin
    ack = '0;
    if (accept) begin
      ack[gnt_idx] = 1'b1;
    end
  end

  assign bus.ack     = ack;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data = fifo_dataOut;
  assign fifo_EN     = 1'b1;
  assign fifo_Rst    = Rst;
  assign fifo_WR     = accept;
  assign fifo_RD     = rd_fire;
  assign fifo_dataIn = accept ? bus.wdata[gnt_idx*DW +: DW] : '0;
  assign level       = level_q;
  assign grant_id    = accept ? gnt_idx : gid_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gid_d       = gid_q;
    burst_cnt_d = burst_cnt_q;
    if (wr_ok) begin
      if (owner_drop) begin
        ptr_d       = scan_base;
        state_d     = StIdle;
        burst_cnt_d = '0;
      end
      if (accept) begin
        gid_d = gnt_idx;
        if (own_hold) begin
          if (32'(burst_cnt_q) + 32'd1 >= MAX_BURST) begin
            ptr_d       = wrap_inc(owner_q);
            state_d     = StIdle;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else begin
          owner_d = gnt_idx;
          if (MAX_BURST == 1) begin
            ptr_d       = wrap_inc(gnt_idx);
            state_d     = StIdle;
            burst_cnt_d = '0;
          end else begin
            state_d     = StOwn;
            burst_cnt_d = BW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    level_d = level_q;
    if (accept) begin
      level_d = level_q + LW'(1);
    end else if (rd_fire) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      owner_q     <= '0;
      gid_q       <= '0;
      burst_cnt_q <= '0;
      level_q     <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      gid_q       <= gid_d;
      burst_cnt_q <= burst_cnt_d;
      level_q     <= level_d;
      rd_valid_q  <= rd_fire;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: instance A (DEPTH 8, MAX_BURST 4) with a FIFO model,
// instance B (DEPTH 16, MAX_BURST 2) for the round-robin grant sequence.
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(4), .DW(32)) bus_a ();
  fifo_wr_arbiter_if #(.NREQ(4), .DW(32)) bus_b ();

  logic        en_a, frst_a, wr_a, rd_a, full_a, empty_a;
  logic [31:0] din_a;
  logic [31:0] dout_a = '0;
  logic [3:0]  level_a;
  logic [1:0]  gid_a;

  logic        en_b, frst_b, wr_b, rd_b, full_b, empty_b;
  logic [31:0] din_b;
  logic [31:0] dout_b = '0;
  logic [4:0]  level_b;
  logic [1:0]  gid_b;

  fifo_wr_arbiter #(.NREQ(4), .DW(32), .DEPTH(8), .MAX_BURST(4)) dut_a (
    .Clk(clk), .Rst(rst), .bus(bus_a),
    .fifo_EN(en_a), .fifo_Rst(frst_a), .fifo_WR(wr_a), .fifo_RD(rd_a),
    .fifo_dataIn(din_a), .fifo_dataOut(dout_a),
    .level(level_a), .full(full_a), .empty(empty_a), .grant_id(gid_a)
  );

  fifo_wr_arbiter #(.NREQ(4), .DW(32), .DEPTH(16), .MAX_BURST(2)) dut_b (
    .Clk(clk), .Rst(rst), .bus(bus_b),
    .fifo_EN(en_b), .fifo_Rst(frst_b), .fifo_WR(wr_b), .fifo_RD(rd_b),
    .fifo_dataIn(din_b), .fifo_dataOut(dout_b),
    .level(level_b), .full(full_b), .empty(empty_b), .grant_id(gid_b)
  );

  // Behavioural FIFO behind instance A with registered read data.
  logic [31:0] mem [16];
  int          wp = 0;
  int          rp = 0;
  always @(posedge clk) begin
    if (frst_a) begin
      wp <= 0;
      rp <= 0;
    end else begin
      if (wr_a) begin
        mem[wp] <= din_a;
        wp      <= (wp + 1) % 16;
      end
      if (rd_a) begin
        dout_a <= mem[rp];
        rp     <= (rp + 1) % 16;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    #1;
    n_tests++; if (level_a !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level_a); end
    n_tests++; if (empty_a !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty_a); end
    n_tests++; if (bus_a.ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0000", bus_a.ack); end
    n_tests++; if (frst_a !== 1'b1) begin n_fail++; $display("FAIL reset_fifo_rst got %b want 1", frst_a); end
    n_tests++; if (en_a !== 1'b1) begin n_fail++; $display("FAIL reset_fifo_en got %b want 1", en_a); end
    n_tests++; if (bus_a.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", bus_a.rd_valid); end
    n_tests++; if (gid_a !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id got %0d want 0", gid_a); end
    rst = 1'b0;
    #1;
    n_tests++; if (frst_a !== 1'b0) begin n_fail++; $display("FAIL release_fifo_rst got %b want 0", frst_a); end
    tick();
  endtask

  task automatic test_fill_to_full();
    logic [31:0] w = 0;
    for (int k = 0; k < 10; k++) begin
      bus_a.req   = 4'b0001;
      bus_a.wdata = {96'h0, w};
      #1;
      n_tests++;
      if (bus_a.ack !== ((k < 8) ? 4'b0001 : 4'b0000)) begin
        n_fail++; $display("FAIL fill_ack[%0d] got %b want %b", k, bus_a.ack, (k < 8) ? 4'b0001 : 4'b0000);
      end
      if (k < 8) begin
        n_tests++; if (din_a !== w) begin n_fail++; $display("FAIL fill_data[%0d] got %h want %h", k, din_a, w); end
      end
      n_tests++;
      if (full_a !== (k >= 8)) begin n_fail++; $display("FAIL fill_full[%0d] got %b want %b", k, full_a, k >= 8); end
      if (k < 8) w++;
      tick();
    end
    bus_a.req = 4'b0;
    // Drain and confirm the stored order 0..7.
    for (int k = 0; k < 9; k++) begin
      bus_a.rd_req = (k < 8);
      #1;
      if (k > 0) begin
        n_tests++;
        if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== 32'(k - 1)) begin
          n_fail++; $display("FAIL drain_data[%0d] got v=%b d=%h want v=1 d=%h", k - 1, bus_a.rd_valid, bus_a.rd_data, k - 1);
        end
      end
      tick();
    end
    n_tests++; if (empty_a !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b want 1", empty_a); end
  endtask

  task automatic test_round_robin();
    int exp;
    for (int i = 0; i < 4; i++) bus_b.wdata[i*32 +: 32] = 32'hB0 + 32'(i);
    bus_b.req = 4'hF;
    for (int k = 0; k < 9; k++) begin
      exp = (k / 2) % 4;
      #1;
      n_tests++;
      if (gid_b !== 2'(exp) || bus_b.ack !== 4'(1 << exp)) begin
        n_fail++; $display("FAIL rr_grant[%0d] got id=%0d ack=%b want id=%0d", k, gid_b, bus_b.ack, exp);
      end
      n_tests++;
      if (din_b !== 32'hB0 + 32'(exp)) begin
        n_fail++; $display("FAIL rr_data[%0d] got %h want %h", k, din_b, 32'hB0 + 32'(exp));
      end
      tick();
    end
    bus_b.req = 4'b0;
  endtask

  task automatic test_read_priority();
    for (int k = 0; k < 3; k++) begin
      bus_a.req = 4'b0010;
      bus_a.wdata[63:32] = 32'h100 + 32'(k);
      tick();
    end
    bus_a.rd_req = 1'b1;
    bus_a.wdata[63:32] = 32'h103;
    #1;
    n_tests++;
    if (rd_a !== 1'b1 || wr_a !== 1'b0 || bus_a.ack !== 4'b0) begin
      n_fail++; $display("FAIL prio_collide got rd=%b wr=%b ack=%b want rd=1 wr=0 ack=0000", rd_a, wr_a, bus_a.ack);
    end
    tick();
    bus_a.rd_req = 1'b0;
    #1;
    n_tests++; if (level_a !== 4'd2) begin n_fail++; $display("FAIL prio_level got %0d want 2", level_a); end
    n_tests++;
    if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== 32'h100) begin
      n_fail++; $display("FAIL prio_rdata got v=%b d=%h want v=1 d=100", bus_a.rd_valid, bus_a.rd_data);
    end
    n_tests++; if (bus_a.ack !== 4'b0010) begin n_fail++; $display("FAIL prio_ack got %b want 0010", bus_a.ack); end
    tick();
    bus_a.req    = 4'b0;
    bus_a.rd_req = 1'b1;
    tick();
    tick();
    tick();
    bus_a.rd_req = 1'b0;
    #1;
    n_tests++; if (level_a !== 4'd0) begin n_fail++; $display("FAIL prio_drain_level got %0d want 0", level_a); end
    tick();
  endtask

  task automatic test_read_empty();
    bus_a.rd_req = 1'b1;
    #1;
    n_tests++; if (rd_a !== 1'b0) begin n_fail++; $display("FAIL empty_rd got %b want 0", rd_a); end
    tick();
    bus_a.rd_req = 1'b0;
    bus_a.req    = 4'b0100;
    bus_a.wdata[95:64] = 32'hA5;
    #1;
    n_tests++; if (bus_a.rd_valid !== 1'b0) begin n_fail++; $display("FAIL empty_rd_valid got %b want 0", bus_a.rd_valid); end
    n_tests++;
    if (bus_a.ack !== 4'b0100 || din_a !== 32'hA5) begin
      n_fail++; $display("FAIL empty_then_write got ack=%b d=%h want ack=0100 d=a5", bus_a.ack, din_a);
    end
    tick();
    bus_a.req = 4'b0;
    #1;
    n_tests++; if (level_a !== 4'd1) begin n_fail++; $display("FAIL empty_then_level got %0d want 1", level_a); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [0:0] st;
    bus_a.req = 4'b1000;
    bus_a.wdata[127:96] = 32'hC0;
    #1;
    n_tests++; if (bus_a.ack !== 4'b1000) begin n_fail++; $display("FAIL burst_first_ack got %b want 1000", bus_a.ack); end
    tick();
    bus_a.wdata[127:96] = 32'hC1;
    tick();
    bus_a.wdata[127:96] = 32'hC2;
    rst = 1'b1;
    bus_a.rd_req = 1'b1;
    #1;
    n_tests++;
    if (bus_a.ack !== 4'b0 || wr_a !== 1'b0 || rd_a !== 1'b0) begin
      n_fail++; $display("FAIL rst_strobes got ack=%b wr=%b rd=%b want all 0", bus_a.ack, wr_a, rd_a);
    end
    tick();
    rst = 1'b0;
    bus_a.rd_req = 1'b0;
    st = dut_a.state_q;
    #1;
    n_tests++; if (st !== 1'b0) begin n_fail++; $display("FAIL rst_state got %b want 0 (idle)", st); end
    n_tests++; if (dut_a.ptr_q !== 2'd0) begin n_fail++; $display("FAIL rst_ptr got %0d want 0", dut_a.ptr_q); end
    n_tests++; if (dut_a.burst_cnt_q !== 3'd0) begin n_fail++; $display("FAIL rst_burst got %0d want 0", dut_a.burst_cnt_q); end
    n_tests++; if (level_a !== 4'd0) begin n_fail++; $display("FAIL rst_level got %0d want 0", level_a); end
    n_tests++;
    if (bus_a.ack !== 4'b1000 || din_a !== 32'hC2) begin
      n_fail++; $display("FAIL rst_represent got ack=%b d=%h want ack=1000 d=c2", bus_a.ack, din_a);
    end
    tick();
    bus_a.req = 4'b0;
    tick();
  endtask

  initial begin
    bus_a.req = '0; bus_a.wdata = '0; bus_a.rd_req = 1'b0;
    bus_b.req = '0; bus_b.wdata = '0; bus_b.rd_req = 1'b0;
    test_reset();
    test_fill_to_full();
    test_round_robin();
    test_read_priority();
    test_read_empty();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
